// File: rtl/processor_pkg.sv
//------------------------------------------------------------------------------
// Module  : processor_pkg
// Brief   : Shared widths, HALT encoding, opcodes and program-memory states.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package processor_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;
  localparam int DEPTH   = 16;

  localparam logic [INSTR_W-1:0] HALT_WORD = 8'hC0;

  // Major opcode sits in the top two bits of each instruction word
  localparam int OP_W = 2;
  localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
  localparam logic [OP_W-1:0] OP_ADD  = 2'b01;
  localparam logic [OP_W-1:0] OP_JMP  = 2'b10;
  localparam logic [OP_W-1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } pm_state_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/program_memory_if.sv
//------------------------------------------------------------------------------
// Module  : program_memory_if
// Brief   : Load port and fetch handshake between loader/fetch stage and memory.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface program_memory_if #(
  parameter int ADDR_W  = processor_pkg::ADDR_W,
  parameter int INSTR_W = processor_pkg::INSTR_W
) ();

  logic               load_we;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               load_err;

  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_ready;
  logic               fetch_valid;
  logic [INSTR_W-1:0] instruction;
  logic               fetch_err;

  modport master (
    output load_we, load_addr, load_data, fetch_req, fetch_addr,
    input  load_err, fetch_ready, fetch_valid, instruction, fetch_err
  );

  modport slave (
    input  load_we, load_addr, load_data, fetch_req, fetch_addr,
    output load_err, fetch_ready, fetch_valid, instruction, fetch_err
  );

endinterface

`default_nettype wire

// File: rtl/program_memory_storage.sv
//------------------------------------------------------------------------------
// Module  : pm_storage
// Brief   : DEPTH x INSTR_W simple dual-port RAM, one write port, registered read.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pm_storage #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  // Callers guarantee both addresses are below DEPTH when their enables are set
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/program_memory.sv
//------------------------------------------------------------------------------
// Module  : program_memory
// Brief   : Writable instruction store: HALT self-fill, load port, 1-cycle fetch.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module program_memory #(
  parameter int                               ADDR_W    = processor_pkg::ADDR_W,
  parameter int                               INSTR_W   = processor_pkg::INSTR_W,
  parameter int                               DEPTH     = processor_pkg::DEPTH,
  parameter logic [processor_pkg::INSTR_W-1:0] HALT_WORD = processor_pkg::HALT_WORD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   load_mode,
  output logic                   init_done,
  program_memory_if.slave        bus
);

  import processor_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  pm_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               fetch_err_q, fetch_err_d;
  logic               halt_sel_q, halt_sel_d;
  logic               load_err_q, load_err_d;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               mem_re;
  logic [INSTR_W-1:0] mem_rdata;

  logic               fetch_accept;
  logic               load_in_range;
  logic               fetch_in_range;

  assign load_in_range  = addr_in_range(32'(bus.load_addr), DEPTH);
  assign fetch_in_range = addr_in_range(32'(bus.fetch_addr), DEPTH);

  // Ready comes from the current state, so a fetch in a mode-switch or clear cycle is still taken
  assign fetch_accept   = bus.fetch_req && (state_q == ST_RUN);
  assign mem_re         = fetch_accept && fetch_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      halt_sel_q    <= 1'b1;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      halt_sel_q    <= halt_sel_d;
      load_err_q    <= load_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = bus.load_addr;
    mem_wdata  = bus.load_data;
    load_err_d = 1'b0;

    if (clear) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = HALT_WORD;
          if (cnt_q == LAST_ADDR) begin
            state_d = load_mode ? ST_LOAD : ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.load_we) begin
            if (load_in_range) begin
              mem_we = 1'b1;
            end else begin
              load_err_d = 1'b1;
            end
          end
          if (!load_mode) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (load_mode) begin
            state_d = ST_LOAD;
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The output mux selects HALT until an in-range fetch lands, so the word holds between fetches
  always_comb begin
    fetch_valid_d = fetch_accept;
    fetch_err_d   = fetch_accept && !fetch_in_range;
    halt_sel_d    = fetch_accept ? !fetch_in_range : halt_sel_q;
  end

  pm_storage #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_storage (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (bus.fetch_addr),
    .rdata_o (mem_rdata)
  );

  assign init_done       = (state_q != ST_INIT);
  assign bus.fetch_ready = (state_q == ST_RUN);
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.load_err    = load_err_q;
  assign bus.instruction = halt_sel_q ? HALT_WORD : mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_program_memory.sv
//------------------------------------------------------------------------------
// Module  : tb_program_memory
// Brief   : Directed and random stimulus against a behavioural program-memory model.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_program_memory;

  localparam int         AW    = 4;
  localparam int         IW    = 8;
  localparam int         DEPTH = 10;
  localparam logic [7:0] HALT  = 8'hC0;

  localparam int M_INIT = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic load_mode;
  logic init_done;

  program_memory_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  program_memory #(
    .ADDR_W    (AW),
    .INSTR_W   (IW),
    .DEPTH     (DEPTH),
    .HALT_WORD (HALT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .load_mode (load_mode),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: whole-memory refill at the end of a DEPTH-cycle INIT window
  int         m_mode;
  int         m_left;
  logic       m_valid, m_ferr, m_lerr;
  logic [7:0] m_instr;
  logic [7:0] m_mem [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= M_INIT;
      m_left  <= DEPTH;
      m_valid <= 1'b0;
      m_ferr  <= 1'b0;
      m_lerr  <= 1'b0;
      m_instr <= HALT;
    end else begin
      m_valid <= (m_mode == M_RUN) && bus.fetch_req;
      m_ferr  <= (m_mode == M_RUN) && bus.fetch_req && (int'(bus.fetch_addr) >= DEPTH);
      if (m_mode == M_RUN && bus.fetch_req)
        m_instr <= (int'(bus.fetch_addr) < DEPTH) ? m_mem[bus.fetch_addr] : HALT;
      m_lerr <= !clear && (m_mode == M_LOAD) && bus.load_we && (int'(bus.load_addr) >= DEPTH);
      if (clear) begin
        m_mode <= M_INIT;
        m_left <= DEPTH;
      end else if (m_mode == M_INIT) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          for (int i = 0; i < 16; i++) m_mem[i] <= HALT;
          m_mode <= load_mode ? M_LOAD : M_RUN;
        end
      end else if (m_mode == M_LOAD) begin
        if (bus.load_we && int'(bus.load_addr) < DEPTH) m_mem[bus.load_addr] <= bus.load_data;
        if (!load_mode) m_mode <= M_RUN;
      end else begin
        if (load_mode) m_mode <= M_LOAD;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("init_done",   32'(init_done),       32'(m_mode != M_INIT));
      chk("fetch_ready", 32'(bus.fetch_ready), 32'(m_mode == M_RUN));
      chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_valid));
      chk("fetch_err",   32'(bus.fetch_err),   32'(m_ferr));
      chk("load_err",    32'(bus.load_err),    32'(m_lerr));
      chk("instruction", 32'(bus.instruction), 32'(m_instr));
    end
  end

  task automatic idle_inputs();
    clear         = 1'b0;
    bus.load_we   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = '0;
  endtask

  task automatic fetch(input logic [3:0] a);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    @(negedge clk);
    bus.fetch_req  = 1'b0;
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    bus.load_we   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    @(negedge clk);
    bus.load_we   = 1'b0;
  endtask

  task automatic check_init_window(input string nm);
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      chk(nm, 32'(init_done), 32'(i == DEPTH));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    load_mode = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_instr", 32'(bus.instruction), 32'h0C0);
    rst_n = 1'b1;
    check_init_window("init_rise");

    fetch(4'd5);
    chk("f5_valid", 32'(bus.fetch_valid), 32'd1);
    chk("f5_instr", 32'(bus.instruction), 32'h0C0);
    chk("f5_err",   32'(bus.fetch_err),   32'd0);

    load_mode = 1'b1;
    @(negedge clk);
    write(4'd0, 8'h43);
    write(4'd1, 8'h55);
    write(4'd4, 8'h05);
    load_mode = 1'b0;
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 4'd0;
    @(negedge clk);
    chk("b2b0", {23'd0, bus.fetch_valid, bus.instruction}, 32'h143);
    bus.fetch_addr = 4'd1;
    @(negedge clk);
    chk("b2b1", {23'd0, bus.fetch_valid, bus.instruction}, 32'h155);
    bus.fetch_addr = 4'd4;
    @(negedge clk);
    chk("b2b2", {23'd0, bus.fetch_valid, bus.instruction}, 32'h105);
    bus.fetch_req = 1'b0;
    @(negedge clk);
    chk("b2b_end", 32'(bus.fetch_valid), 32'd0);

    load_mode = 1'b1;
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 4'd12;
    write(4'd12, 8'h77);
    chk("oor_lerr",  32'(bus.load_err),    32'd1);
    chk("load_rdy",  32'(bus.fetch_ready), 32'd0);
    chk("load_nval", 32'(bus.fetch_valid), 32'd0);
    load_mode = 1'b0;
    @(negedge clk);
    chk("oor_lerr_end", 32'(bus.load_err),    32'd0);
    chk("sw_nval",      32'(bus.fetch_valid), 32'd0);
    @(negedge clk);
    chk("oor_fetch", {22'd0, bus.fetch_valid, bus.fetch_err, bus.instruction}, 32'h3C0);
    bus.fetch_req = 1'b0;
    fetch(4'd2);
    chk("no_alias", {22'd0, bus.fetch_valid, bus.fetch_err, bus.instruction}, 32'h2C0);

    clear = 1'b1;
    fetch(4'd0);
    clear = 1'b0;
    chk("clr_inflight", {22'd0, bus.fetch_valid, init_done, bus.instruction}, 32'h243);
    check_init_window("clr_init");
    fetch(4'd0);
    chk("clr_refill", {22'd0, bus.fetch_valid, bus.fetch_err, bus.instruction}, 32'h2C0);

    for (int c = 0; c < 800; c++) begin
      clear = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) load_mode = ~load_mode;
      bus.load_we    = 1'($urandom_range(0, 1));
      bus.load_addr  = 4'($urandom_range(0, 15));
      bus.load_data  = 8'($urandom);
      bus.fetch_req  = 1'($urandom_range(0, 1));
      bus.fetch_addr = 4'($urandom_range(0, 15));
      @(negedge clk);
    end

    idle_inputs();
    load_mode = 1'b1;
    for (int k = 0; k < 40 && !(init_done && !bus.fetch_ready); k++) @(negedge clk);
    @(negedge clk);
    chk("reach_load", {30'd0, init_done, bus.fetch_ready}, 32'd2);
    write(4'd2, 8'h99);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", {27'd0, init_done, bus.fetch_ready, bus.fetch_valid, bus.fetch_err, bus.load_err}, 32'd0);
    chk("arst_instr", 32'(bus.instruction), 32'h0C0);
    @(negedge clk);
    rst_n     = 1'b1;
    load_mode = 1'b0;
    check_init_window("arst_init");
    fetch(4'd2);
    chk("arst_refill", {22'd0, bus.fetch_valid, bus.fetch_err, bus.instruction}, 32'h2C0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_memory.md
Name: program_memory

Overview:
Parametrised, writable instruction store for the 4-bit processor; next generation of the fixed instruction ROM. After reset it self-fills every word with the HALT encoding. It then accepts a program over a load port, and serves registered, 1-cycle-latency fetches to the control unit through a req/ready/valid handshake. Sits between the program loader (bench or boot logic) and the fetch stage.

Parameters:
ADDR_W, 4, fetch/load address width
INSTR_W, 8, instruction word width
DEPTH, 16, number of implemented words; must be ≤ 2**ADDR_W; addresses ≥ DEPTH are out of range
HALT_WORD, 8'hC0, fill value and out-of-range response

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  single-cycle pulse; restarts the fill sequence from any state
load_mode  in  1  level; 1 = LOAD mode, 0 = RUN mode
load_we  in  1  write strobe, honoured only in LOAD
load_addr  in  ADDR_W  write address
load_data  in  INSTR_W  write data
load_err  out  1  1-cycle pulse: write ignored because the address was out of range
init_done  out  1  high once the fill completes; low during INIT
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  fetch address (PC)
fetch_ready  out  1  high only in RUN
fetch_valid  out  1  1-cycle pulse, one cycle after an accepted fetch
instruction  out  INSTR_W  fetched word; holds its value until the next accepted fetch
fetch_err  out  1  qualifies fetch_valid; the fetched address was out of range

Behaviour:
- Reset (async assert, sync release) values:
  - state = INIT, fill counter = 0
  - init_done = 0, fetch_ready = 0, fetch_valid = 0, fetch_err = 0, load_err = 0
  - instruction = HALT_WORD
  - Memory contents are not reset directly; the INIT sweep clears them.
- States: INIT, LOAD, RUN.
- INIT:
  - Writes HALT_WORD to mem[cnt] each cycle, cnt = 0 .. DEPTH-1, so the sweep takes exactly DEPTH cycles.
  - After the write to DEPTH-1: init_done rises, and the next state is LOAD if load_mode = 1, else RUN.
  - load_we and fetch_req are ignored; no load_err is raised.
- LOAD:
  - load_we with load_addr < DEPTH writes mem[load_addr] = load_data at the edge; a read in the following cycle sees the new data.
  - load_addr ≥ DEPTH: no write; load_err pulses the next cycle.
  - fetch_ready = 0.
  - load_mode = 0 moves to RUN next cycle. A write in the same cycle as the switch is still performed.
- RUN:
  - fetch_ready = 1. A fetch is accepted when fetch_req & fetch_ready in the same cycle.
  - Accept at edge N: at edge N+1, fetch_valid = 1 and instruction = mem[fetch_addr], or HALT_WORD with fetch_err = 1 if out of range.
  - Back-to-back fetches are allowed every cycle, with throughput 1/cycle.
  - load_we is ignored and load_err stays 0.
  - load_mode = 1 moves to LOAD next cycle. A fetch in the switching cycle is still accepted, because ready is evaluated on the current state.
- clear: any state goes to INIT next cycle with cnt = 0 and init_done = 0. An in-flight fetch still completes (valid next cycle). clear takes priority over load_mode and load_we.
- Non-power-of-two DEPTH: the range check is addr < DEPTH; never alias or wrap.
- fetch_err and fetch_valid are both 0 when no fetch was accepted.

Decomposition:
- Shared package (processor_pkg): INSTR_W, ADDR_W, HALT_WORD, opcode constants, and the state enum for INIT/LOAD/RUN.
- One natural sub-module: pm_storage, a simple dual-port RAM with 1 write port and 1 registered read port, DEPTH × INSTR_W.
- Control FSM, fill counter and range checks live in program_memory.

Test Plan:
- Reset, then idle for DEPTH+1 cycles -> init_done rises exactly DEPTH cycles after reset release. Then RUN and fetch addr 5 -> instruction = 8'hC0, fetch_valid pulse, fetch_err = 0.
- LOAD writes 0x43@0, 0x55@1, 0x05@4; load_mode = 0; fetch 0,1,4 back-to-back -> valid on 3 consecutive cycles with 0x43, 0x55, 0x05.
- DEPTH = 10: write to addr 12 -> load_err pulse, no write. Fetch addr 12 -> instruction = 8'hC0, fetch_err = 1.
- fetch_req held in LOAD -> fetch_ready = 0, no fetch_valid. Switch to RUN -> first fetch valid 1 cycle after acceptance.
- clear mid-RUN with a fetch in flight -> fetch_valid next cycle. init_done = 0 for DEPTH cycles. The previously loaded addr 0 then reads 8'hC0.
- rst_n asserted mid-LOAD (asynchronous, between edges) -> all outputs reach reset values immediately; the FSM restarts in INIT.
